// File: rtl/water_box_counter.sv
// ---------------------------------------------------------------------------
// water_box_counter
//
// Turns raw, asynchronous fill/drain valve requests into the 3-bit fill count
// and the last-movement direction flag consumed by the water-box level
// encoder.
//
// Request path (per request): 2-flop synchroniser -> debounce filter.
// Control path: IDLE / FILL / DRAIN sequencer with a step timer; the count
// saturates at 0 (empty) and 7 (full).
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   fill_req   in   raw fill valve request (asynchronous to clk)
//   drain_req  in   raw drain valve request (asynchronous to clk)
//   count      out  [2:0] fill count, 0 = empty, 7 = full
//   direction  out  1 = last movement up (filling), 0 = down (draining)
//   busy       out  high while filling or draining
//   full       out  count == 7
//   empty      out  count == 0
// ---------------------------------------------------------------------------

// Synchroniser plus debounce filter for one request line.
// The filtered value flips one edge after the mismatch counter has reached
// DEBOUNCE, whatever the synchronised input does on that edge. A request
// that is stable for DEBOUNCE samples is therefore accepted; anything
// shorter clears the counter before it gets there.
module water_box_debounce #(
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filtered
);

    localparam logic [7:0] DEB_LIMIT = 8'(DEBOUNCE);

    logic       sync_a;
    logic       sync_b;
    logic [7:0] mismatch_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filtered     <= 1'b0;
            mismatch_cnt <= 8'd0;
        end else if (mismatch_cnt == DEB_LIMIT) begin
            filtered     <= ~filtered;
            mismatch_cnt <= 8'd0;
        end else if (sync_b != filtered) begin
            mismatch_cnt <= mismatch_cnt + 8'd1;
        end else begin
            mismatch_cnt <= 8'd0;
        end
    end

endmodule

// ---------------------------------------------------------------------------
// Sequencer
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no movement; count and direction hold
//   FILL   | filling: count += 1 every STEP_CYCLES edges, stop at 7
//   DRAIN  | draining: count -= 1 every STEP_CYCLES edges, stop at 0
// ---------------------------------------------------------------------------
module water_box_counter #(
    parameter int unsigned STEP_CYCLES = 4,
    parameter int unsigned DEBOUNCE    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fill_req,
    input  logic       drain_req,
    output logic [2:0] count,
    output logic       direction,
    output logic       busy,
    output logic       full,
    output logic       empty
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // The step timer counts down from STEP_CYCLES-1; a step is taken on the
    // edge that finds it at zero, so each step spans exactly STEP_CYCLES
    // edges after entry or after the previous step.
    localparam logic [7:0] STEP_LAST = 8'(STEP_CYCLES - 1);

    logic       f_fill;
    logic       f_drain;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] count_nxt;
    logic       direction_nxt;
    logic [7:0] timer;
    logic [7:0] timer_nxt;
    logic       busy_nxt;
    logic       full_nxt;
    logic       empty_nxt;

    water_box_debounce #(.DEBOUNCE(DEBOUNCE)) u_fill_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw      (fill_req),
        .filtered (f_fill)
    );

    water_box_debounce #(.DEBOUNCE(DEBOUNCE)) u_drain_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw      (drain_req),
        .filtered (f_drain)
    );

    // State and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            count     <= 3'd0;
            direction <= 1'b0;
            timer     <= 8'd0;
            busy      <= 1'b0;
            full      <= 1'b0;
            empty     <= 1'b1;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            direction <= direction_nxt;
            timer     <= timer_nxt;
            busy      <= busy_nxt;
            full      <= full_nxt;
            empty     <= empty_nxt;
        end
    end

    // Next-state logic. A request that drops (or a conflicting request that
    // appears) mid-step aborts before the step check, so a partly timed step
    // is simply thrown away.
    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        direction_nxt = direction;
        timer_nxt     = timer;

        unique case (state)
            ST_IDLE: begin
                timer_nxt = 8'd0;
                if (f_fill && !f_drain && (count != 3'd7)) begin
                    state_nxt     = ST_FILL;
                    direction_nxt = 1'b1;
                    timer_nxt     = STEP_LAST;
                end else if (f_drain && !f_fill && (count != 3'd0)) begin
                    state_nxt     = ST_DRAIN;
                    direction_nxt = 1'b0;
                    timer_nxt     = STEP_LAST;
                end
            end

            ST_FILL: begin
                if (!f_fill || f_drain) begin
                    state_nxt = ST_IDLE;
                    timer_nxt = 8'd0;
                end else if (timer == 8'd0) begin
                    count_nxt = count + 3'd1;
                    timer_nxt = STEP_LAST;
                    if (count == 3'd6) begin
                        state_nxt = ST_IDLE;
                        timer_nxt = 8'd0;
                    end
                end else begin
                    timer_nxt = timer - 8'd1;
                end
            end

            ST_DRAIN: begin
                if (!f_drain || f_fill) begin
                    state_nxt = ST_IDLE;
                    timer_nxt = 8'd0;
                end else if (timer == 8'd0) begin
                    count_nxt = count - 3'd1;
                    timer_nxt = STEP_LAST;
                    if (count == 3'd1) begin
                        state_nxt = ST_IDLE;
                        timer_nxt = 8'd0;
                    end
                end else begin
                    timer_nxt = timer - 8'd1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                timer_nxt = 8'd0;
            end
        endcase
    end

    // Status flags are derived from the next values so that, once
    // registered, they line up with count/state in the same cycle.
    always_comb begin
        busy_nxt  = (state_nxt != ST_IDLE);
        full_nxt  = (count_nxt == 3'd7);
        empty_nxt = (count_nxt == 3'd0);
    end

endmodule

// File: tb/tb_water_box_counter.sv
// ---------------------------------------------------------------------------
// Testbench for water_box_counter (STEP_CYCLES = 4, DEBOUNCE = 3).
// A behavioural model derives the expected outputs from raw request history
// and is compared with the DUT on every falling clock edge; directed phases
// add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_water_box_counter;

    localparam int S = 4;
    localparam int D = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fill_req = 1'b0;
    logic       drain_req = 1'b0;
    logic [2:0] count;
    logic       direction;
    logic       busy;
    logic       full;
    logic       empty;

    int checks = 0;
    int errors = 0;

    water_box_counter #(.STEP_CYCLES(S), .DEBOUNCE(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fill_req  (fill_req),
        .drain_req (drain_req),
        .count     (count),
        .direction (direction),
        .busy      (busy),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Raw request history indexed by edge number since reset release.
    bit hist_f [0:4095];
    bit hist_d [0:4095];
    int n;
    bit mf, md;
    int lt_f, lt_d;
    int mcount;
    bit mdir, filling, draining;
    int entry;

    task automatic model_reset();
        n = 0; mf = 0; md = 0; lt_f = -1; lt_d = -1;
        mcount = 0; mdir = 0; filling = 0; draining = 0; entry = 0;
    endtask

    // Value of the request as seen by the filter at edge m: the raw value
    // sampled two edges earlier (zero before reset release).
    function automatic bit seen(input bit is_fill, input int m);
        logic [11:0] idx;
        if (m - 2 < 0) return 1'b0;
        idx = 12'(m - 2);
        return is_fill ? hist_f[idx] : hist_d[idx];
    endfunction

    // Filter flips at edge nn when the D samples at edges nn-D..nn-1 all
    // disagreed with it and all came after its last flip.
    function automatic bit flips(input bit is_fill, input int nn, input bit cur, input int lt);
        if (nn - D < lt + 1) return 1'b0;
        for (int k = 1; k <= D; k++)
            if (seen(is_fill, nn - k) == cur) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        bit nf, nd;
        logic [11:0] idx;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                idx = 12'(n);
                hist_f[idx] = fill_req;
                hist_d[idx] = drain_req;
                if (filling) begin
                    if (!mf || md) filling = 0;
                    else if ((n - entry) % S == 0) begin
                        mcount++;
                        if (mcount == 7) filling = 0;
                    end
                end else if (draining) begin
                    if (!md || mf) draining = 0;
                    else if ((n - entry) % S == 0) begin
                        mcount--;
                        if (mcount == 0) draining = 0;
                    end
                end else if (mf && !md && mcount < 7) begin
                    filling = 1; mdir = 1; entry = n;
                end else if (md && !mf && mcount > 0) begin
                    draining = 1; mdir = 0; entry = n;
                end
                nf = mf; nd = md;
                if (flips(1'b1, n, mf, lt_f)) begin nf = !mf; lt_f = n; end
                if (flips(1'b0, n, md, lt_d)) begin nd = !md; lt_d = n; end
                mf = nf; md = nd;
                n++;
            end
        end
    end

    // Compare process
    initial begin
        forever begin
            @(negedge clk);
            chk("model_count", int'(count), mcount);
            chk("model_direction", int'(direction), int'(mdir));
            chk("model_busy", int'(busy), int'(filling || draining));
            chk("model_full", int'(full), int'(mcount == 7));
            chk("model_empty", int'(empty), int'(mcount == 0));
        end
    end

    task automatic wait_count(input int target, input int budget);
        bit hit = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (int'(count) == target) begin
                hit = 1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_count: count=%0d, expected %0d within %0d cycles", count, target, budget);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        fill_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_direction", int'(direction), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_busy", int'(busy), 0);

        // Release with fill held: FILL at edge 6, first step at edge 10.
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("lat_busy_before_fill", int'(busy), 0);
        @(negedge clk);
        chk("lat_busy_fill", int'(busy), 1);
        chk("lat_dir_fill", int'(direction), 1);
        repeat (3) @(negedge clk);
        chk("lat_count_edge9", int'(count), 0);
        @(negedge clk);
        chk("lat_count_edge10", int'(count), 1);

        // Full fill: count 6 after edge 33, 7 at edge 34.
        repeat (23) @(negedge clk);
        chk("fill_count_edge33", int'(count), 6);
        @(negedge clk);
        chk("fill_count_full", int'(count), 7);
        chk("fill_full_flag", int'(full), 1);
        chk("fill_busy_stop", int'(busy), 0);
        repeat (20) @(negedge clk);
        chk("fill_sat_count", int'(count), 7);
        chk("fill_sat_busy", int'(busy), 0);

        // Drain from 7; release once count reads 5 so the step to 4 completes
        // and the next one is aborted.
        fill_req = 1'b0;
        drain_req = 1'b1;
        wait_count(5, 40);
        drain_req = 1'b0;
        repeat (12) @(negedge clk);
        chk("hyst_count", int'(count), 4);
        chk("hyst_direction", int'(direction), 0);
        chk("hyst_busy", int'(busy), 0);

        // Fill again: direction flips only on FILL entry.
        fill_req = 1'b1;
        repeat (6) @(negedge clk);
        chk("refill_dir_before", int'(direction), 0);
        @(negedge clk);
        chk("refill_dir_entry", int'(direction), 1);
        chk("refill_busy_entry", int'(busy), 1);
        wait_count(5, 40);
        fill_req = 1'b0;
        repeat (12) @(negedge clk);
        chk("refill_count", int'(count), 6);
        chk("refill_busy", int'(busy), 0);

        // 2-cycle glitch: rejected.
        fill_req = 1'b1;
        repeat (2) @(negedge clk);
        fill_req = 1'b0;
        repeat (15) @(negedge clk);
        chk("glitch2_count", int'(count), 6);
        chk("glitch2_busy", int'(busy), 0);

        // 3-cycle pulse: FILL at edge 6, aborted at edge 10 without a step.
        fill_req = 1'b1;
        repeat (3) @(negedge clk);
        fill_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("pulse3_busy_entry", int'(busy), 1);
        repeat (3) @(negedge clk);
        chk("pulse3_busy_edge9", int'(busy), 1);
        @(negedge clk);
        chk("pulse3_busy_exit", int'(busy), 0);
        chk("pulse3_count", int'(count), 6);

        // Drain to 3.
        drain_req = 1'b1;
        wait_count(4, 40);
        drain_req = 1'b0;
        repeat (12) @(negedge clk);
        chk("drain3_count", int'(count), 3);
        chk("drain3_direction", int'(direction), 0);

        // Conflict: both requests -> stay IDLE.
        fill_req = 1'b1;
        drain_req = 1'b1;
        repeat (20) @(negedge clk);
        chk("conflict_count", int'(count), 3);
        chk("conflict_busy", int'(busy), 0);
        drain_req = 1'b0;
        repeat (10) @(negedge clk);
        chk("conflict_fill_busy", int'(busy), 1);
        chk("conflict_count_edge9", int'(count), 3);
        @(negedge clk);
        chk("conflict_count_edge10", int'(count), 4);
        chk("conflict_direction", int'(direction), 1);
        repeat (4) @(negedge clk);
        chk("midstep_count", int'(count), 5);
        repeat (2) @(negedge clk);
        chk("midstep_busy", int'(busy), 1);

        // Asynchronous reset pulse between clock edges.
        #2 rst_n = 1'b0;
        #1;
        chk("async_count", int'(count), 0);
        chk("async_direction", int'(direction), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_full", int'(full), 0);
        chk("async_empty", int'(empty), 1);
        #1 rst_n = 1'b1;

        // Recovery with fill still held.
        repeat (10) @(negedge clk);
        chk("recover_count_edge9", int'(count), 0);
        @(negedge clk);
        chk("recover_count_edge10", int'(count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
